alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational 32-bit ALU (xor/logic/add unit with eq/carry/overflow flags) between two requesters. Each requester issues an operation with a valid/ready handshake. The block arbitrates round-robin, drives the shared ALU from registered operands and captures the result and flags. It returns them to the winning requester through a per-requester valid/ready response channel. It sits between the ALU instance and the two client blocks (e.g. control unit and test sequencer).

Parameters:
WIDTH, 32, operand/result width
OPW, 3, operation code width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_op  in  OPW  requester 0 op code
req0_a  in  WIDTH  requester 0 operand a
req0_b  in  WIDTH  requester 0 operand b
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
rsp0_valid  out  1  response pending for requester 0
rsp0_ready  in  1  requester 0 takes response
rsp1_valid  out  1  response pending for requester 1
rsp1_ready  in  1  requester 1 takes response
rsp_s  out  WIDTH  captured result (shared by both channels)
rsp_eq  out  1  captured equal flag
rsp_carry  out  1  captured carry flag
rsp_of  out  1  captured overflow flag
rsp_err  out  1  op code was illegal
alu_a  out  WIDTH  to shared ALU operand a
alu_b  out  WIDTH  to shared ALU operand b
alu_op  out  OPW  to shared ALU op select
alu_s  in  WIDTH  ALU result
alu_eq  in  1  ALU equal flag
alu_cary  in  1  ALU carry flag
alu_of  in  1  ALU overflow flag
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins first tie).
  - All ready/valid outputs 0; rsp_s, rsp_eq, rsp_carry, rsp_of, rsp_err=0.
  - alu_a, alu_b, alu_op=0; busy=0.
- Reset mid-operation: the in-flight transaction is dropped and no response is issued.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE grant:
  - If exactly one reqN_valid is set, grant N.
  - If both are set, grant the one != last_grant.
  - reqN_ready = (state==IDLE) && grant==N, combinational from the valids. At most one ready is high per cycle.
- Accept: valid && ready. Latch op, a, b and owner id, then go to EXEC. With no valid, stay in IDLE.
- Requester obligation: a requester must hold op, a and b stable while valid && !ready.
- ALU drive: alu_a, alu_b, alu_op come from the latched registers in all non-IDLE states and are held until return to IDLE (value in IDLE is don't-care but registered).
- EXEC (1 cycle): capture into the rsp_* registers, then go to RESP.
  - Legal op: capture alu_s, alu_eq, alu_cary, alu_of.
  - Illegal op (op >= OP_COUNT): rsp_s=0, flags=0, rsp_err=1. alu_op is still driven.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - rsp_* are held stable until rsp<owner>_ready.
  - On handshake: last_grant <= owner, go to IDLE.
  - Backpressure is unbounded; a new request is not accepted during RESP.
- Latency: accept at cycle T, EXEC at T+1, rsp valid from T+2. Minimum spacing between accepts is 3 cycles.
- Fairness: a continuously asserting requester cannot starve the other; with both valid, grants strictly alternate.
- Wrap-around and flags are computed by the ALU and passed through unmodified.

Decomposition:
- Package alu_pkg:
  - Op code localparams: OP_XOR=0, OP_AND=1, OP_OR=2, OP_ADD=3, OP_SUB=4, OP_NOR=5, OP_COUNT=6.
  - FSM state encoding: IDLE=0, EXEC=1, RESP=2.
  - Default WIDTH.
- One natural sub-module, rr_arbiter2: two-way round-robin grant logic with a last_grant input. The FSM, operand registers and response registers stay in the top.

Test Plan:
1. req0 only: op=XOR, a=FFFF0000, b=0000FFFF, rsp0_ready=1. Expect req0_ready same cycle; rsp0_valid at T+2 with rsp_s=FFFFFFFF, eq=0, err=0; rsp1_valid never set.
2. Both valid at once after reset: req0 XOR FFFFFFFF^FFFFFFFF, req1 XOR 55555555^AAAAAAAA. Expect req0 served first (rsp_s=00000000), then req1 (rsp_s=FFFFFFFF). Grants alternate 0,1,0,1 over 4 back-to-back ops.
3. Backpressure: rsp1_ready held low for 5 cycles. Expect rsp1_valid and rsp_s stable for all 5 cycles, req0_ready=0 throughout; IDLE is entered the cycle after the handshake.
4. Illegal op=7 on req1. Expect rsp_err=1, rsp_s=0, all flags 0; the next legal op returns err=0.
5. Assert rst during EXEC. Expect the next cycle to show state IDLE, all outputs 0, and no rspN_valid ever raised for the dropped op; the first op after reset goes to requester 0 on a tie.
6. ALU flag pass-through: op=ADD with a=FFFFFFFF, b=1 on a reference ALU model. Expect rsp_s=0, rsp_carry=1, rsp_of=0, matching the alu_* inputs captured in EXEC.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: default widths, ALU op
// codes, FSM state encoding and an op-code legality helper.
// No ports (package).
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_OPW   = 3;

  localparam logic [2:0] OP_XOR = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam int         OP_COUNT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Codes at or above OP_COUNT have no ALU function behind them.
  function automatic logic isLegalOp(input int op);
    return (op < OP_COUNT);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the arbiter, its two clients and the shared ALU.
// Signals:
//   req0_*/req1_*   request channels (valid/ready, op, a, b)
//   rsp0_*/rsp1_*   response valid/ready per requester
//   rsp_s/eq/carry/of/err  shared captured response payload
//   alu_a/b/op      drive to the shared ALU; alu_s/eq/cary/of its results
//   busy            arbiter not idle
// Modports: slave = arbiter view, master = client/ALU side view.
interface alu_share_arbiter_if import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_s;
  logic             rsp_eq;
  logic             rsp_carry;
  logic             rsp_of;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_s;
  logic             alu_eq;
  logic             alu_cary;
  logic             alu_of;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp1_valid,
    input  rsp0_ready, rsp1_ready,
    output rsp_s, rsp_eq, rsp_carry, rsp_of, rsp_err,
    output alu_a, alu_b, alu_op,
    input  alu_s, alu_eq, alu_cary, alu_of,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid,
    output rsp0_ready, rsp1_ready,
    input  rsp_s, rsp_eq, rsp_carry, rsp_of, rsp_err,
    input  alu_a, alu_b, alu_op,
    output alu_s, alu_eq, alu_cary, alu_of,
    input  busy
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// requester that was NOT granted last time wins.
// Ports:
//   i_valid0/i_valid1  request present
//   i_lastGrant        id of the previously served requester
//   o_grant0/o_grant1  one-hot (or zero) grant
module rr_arbiter2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_lastGrant,
  output logic o_grant0,
  output logic o_grant1
);

  assign o_grant0 = i_valid0 && (!i_valid1 || i_lastGrant);
  assign o_grant1 = i_valid1 && (!i_valid0 || !i_lastGrant);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. An accepted request
// is latched, driven onto the ALU for one EXEC cycle, and the captured
// result is held on the owner's response channel until taken.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (drops any in-flight operation)
//   bus  alu_share_arbiter_if slave modport (requests, responses, ALU, busy)
module alu_share_arbiter import alu_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastGrant;
  logic             r_owner;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rspS;
  logic             r_rspEq;
  logic             r_rspCarry;
  logic             r_rspOf;
  logic             r_rspErr;

  logic w_grant0;
  logic w_grant1;
  logic w_accept0;
  logic w_accept1;
  logic w_accept;
  logic w_rspHandshake;

  rr_arbiter2 u_arb (
    .i_valid0   (bus.req0_valid),
    .i_valid1   (bus.req1_valid),
    .i_lastGrant(r_lastGrant),
    .o_grant0   (w_grant0),
    .o_grant1   (w_grant1)
  );

  // Ready is masked during reset so no handshake appears to complete then.
  assign bus.req0_ready = !rst && (r_state == IDLE) && w_grant0;
  assign bus.req1_ready = !rst && (r_state == IDLE) && w_grant1;

  assign w_accept0 = bus.req0_valid && bus.req0_ready;
  assign w_accept1 = bus.req1_valid && bus.req1_ready;
  assign w_accept  = w_accept0 || w_accept1;

  assign w_rspHandshake = (r_state == RESP) &&
                          (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.rsp0_valid = (r_state == RESP) && !r_owner;
  assign bus.rsp1_valid = (r_state == RESP) &&  r_owner;
  assign bus.rsp_s      = r_rspS;
  assign bus.rsp_eq     = r_rspEq;
  assign bus.rsp_carry  = r_rspCarry;
  assign bus.rsp_of     = r_rspOf;
  assign bus.rsp_err    = r_rspErr;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_op     = r_op;
  assign bus.busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    if (w_rspHandshake) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand latch on accept, result capture in EXEC, fairness pointer
  // updated only when a response is actually handed back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rspS      <= '0;
      r_rspEq     <= 1'b0;
      r_rspCarry  <= 1'b0;
      r_rspOf     <= 1'b0;
      r_rspErr    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_accept1;
        r_op    <= w_accept1 ? bus.req1_op : bus.req0_op;
        r_a     <= w_accept1 ? bus.req1_a  : bus.req0_a;
        r_b     <= w_accept1 ? bus.req1_b  : bus.req0_b;
      end
      if (r_state == EXEC) begin
        if (isLegalOp(int'(r_op))) begin
          r_rspS     <= bus.alu_s;
          r_rspEq    <= bus.alu_eq;
          r_rspCarry <= bus.alu_cary;
          r_rspOf    <= bus.alu_of;
          r_rspErr   <= 1'b0;
        end else begin
          r_rspS     <= '0;
          r_rspEq    <= 1'b0;
          r_rspCarry <= 1'b0;
          r_rspOf    <= 1'b0;
          r_rspErr   <= 1'b1;
        end
      end
      if (w_rspHandshake) r_lastGrant <= r_owner;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter. A behavioural ALU
// stands in for the shared unit; all expected values are hand-computed.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   testCount = 0;
  int   failCount = 0;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock generation, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU; illegal codes deliberately produce nonzero garbage
  always_comb begin
    logic [32:0] sum;
    sum          = '0;
    bus.alu_s    = '0;
    bus.alu_cary = 1'b0;
    bus.alu_of   = 1'b0;
    bus.alu_eq   = (bus.alu_a == bus.alu_b);
    case (bus.alu_op)
      OP_XOR: bus.alu_s = bus.alu_a ^ bus.alu_b;
      OP_AND: bus.alu_s = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_s = bus.alu_a | bus.alu_b;
      OP_NOR: bus.alu_s = ~(bus.alu_a | bus.alu_b);
      OP_ADD: begin
        sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_s    = sum[31:0];
        bus.alu_cary = sum[32];
        bus.alu_of   = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      end
      OP_SUB: begin
        sum          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_s    = sum[31:0];
        bus.alu_cary = sum[32];
        bus.alu_of   = (bus.alu_a[31] != bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      end
      default: begin
        bus.alu_s    = bus.alu_a;
        bus.alu_cary = 1'b1;
        bus.alu_of   = 1'b1;
      end
    endcase
  end

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int who, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic dropRequest(input int who);
    if (who == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("rst_rsp_s", bus.rsp_s, 0);
    checkOutput("rst_rsp_err", bus.rsp_err, 0);
    checkOutput("rst_alu_a", bus.alu_a, 0);
    checkOutput("rst_alu_op", bus.alu_op, 0);
    checkOutput("rst_req0_ready", bus.req0_ready, 0);
    rst = 1'b0;

    // Test 1: lone requester 0, XOR
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    applyStimulus(0, OP_XOR, 32'hFFFF0000, 32'h0000FFFF);
    #1;
    checkOutput("t1_req0_ready", bus.req0_ready, 1);
    checkOutput("t1_req1_ready", bus.req1_ready, 0);
    tick();
    dropRequest(0);
    checkOutput("t1_exec_busy", bus.busy, 1);
    checkOutput("t1_alu_a", bus.alu_a, 32'hFFFF0000);
    checkOutput("t1_alu_b", bus.alu_b, 32'h0000FFFF);
    checkOutput("t1_exec_rsp0_valid", bus.rsp0_valid, 0);
    tick();
    checkOutput("t1_rsp0_valid", bus.rsp0_valid, 1);
    checkOutput("t1_rsp_s", bus.rsp_s, 32'hFFFFFFFF);
    checkOutput("t1_rsp_eq", bus.rsp_eq, 0);
    checkOutput("t1_rsp_err", bus.rsp_err, 0);
    checkOutput("t1_rsp1_valid", bus.rsp1_valid, 0);
    tick();
    checkOutput("t1_idle_busy", bus.busy, 0);
    checkOutput("t1_idle_rsp0_valid", bus.rsp0_valid, 0);

    // Test 2: both valid from reset, grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, OP_XOR, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(1, OP_XOR, 32'h55555555, 32'hAAAAAAAA);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("t2_req0_ready", bus.req0_ready, (k % 2 == 0) ? 1 : 0);
      checkOutput("t2_req1_ready", bus.req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      checkOutput("t2_exec_req0_ready", bus.req0_ready, 0);
      tick();
      checkOutput("t2_rsp0_valid", bus.rsp0_valid, (k % 2 == 0) ? 1 : 0);
      checkOutput("t2_rsp1_valid", bus.rsp1_valid, (k % 2 == 1) ? 1 : 0);
      checkOutput("t2_rsp_s", bus.rsp_s, (k % 2 == 0) ? 32'h00000000 : 32'hFFFFFFFF);
      checkOutput("t2_resp_req1_ready", bus.req1_ready, 0);
      tick();
    end
    dropRequest(0);
    dropRequest(1);

    // Test 3: backpressure on requester 1 with requester 0 waiting
    bus.rsp1_ready = 0;
    applyStimulus(1, OP_ADD, 32'h00000001, 32'h00000002);
    #1;
    checkOutput("t3_req1_ready", bus.req1_ready, 1);
    tick();
    dropRequest(1);
    applyStimulus(0, OP_XOR, 32'h0, 32'h0);
    #1;
    checkOutput("t3_exec_req0_ready", bus.req0_ready, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("t3_hold_rsp1_valid", bus.rsp1_valid, 1);
      checkOutput("t3_hold_rsp_s", bus.rsp_s, 32'h00000003);
      checkOutput("t3_hold_req0_ready", bus.req0_ready, 0);
      tick();
    end
    bus.rsp1_ready = 1;
    #1;
    checkOutput("t3_final_rsp1_valid", bus.rsp1_valid, 1);
    tick();
    checkOutput("t3_idle_busy", bus.busy, 0);
    checkOutput("t3_idle_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("t3_idle_req0_ready", bus.req0_ready, 1);
    tick();
    dropRequest(0);
    tick();
    checkOutput("t3_rsp0_valid", bus.rsp0_valid, 1);
    checkOutput("t3_rsp0_s", bus.rsp_s, 32'h0);
    checkOutput("t3_rsp0_eq", bus.rsp_eq, 1);
    tick();

    // Test 4: illegal op on requester 1, then a legal one
    applyStimulus(1, 3'd7, 32'h12345678, 32'h12345678);
    #1;
    checkOutput("t4_req1_ready", bus.req1_ready, 1);
    tick();
    dropRequest(1);
    checkOutput("t4_alu_op", bus.alu_op, 7);
    tick();
    checkOutput("t4_rsp1_valid", bus.rsp1_valid, 1);
    checkOutput("t4_rsp_err", bus.rsp_err, 1);
    checkOutput("t4_rsp_s", bus.rsp_s, 0);
    checkOutput("t4_rsp_eq", bus.rsp_eq, 0);
    checkOutput("t4_rsp_carry", bus.rsp_carry, 0);
    checkOutput("t4_rsp_of", bus.rsp_of, 0);
    tick();
    applyStimulus(1, OP_OR, 32'h000000F0, 32'h0000000F);
    tick();
    dropRequest(1);
    tick();
    checkOutput("t4_legal_rsp1_valid", bus.rsp1_valid, 1);
    checkOutput("t4_legal_rsp_s", bus.rsp_s, 32'h000000FF);
    checkOutput("t4_legal_rsp_err", bus.rsp_err, 0);
    tick();

    // Test 6: flag pass-through for ADD carry and SUB overflow
    applyStimulus(0, OP_ADD, 32'hFFFFFFFF, 32'h00000001);
    tick();
    dropRequest(0);
    checkOutput("t6_alu_op", bus.alu_op, 3);
    tick();
    checkOutput("t6_add_s", bus.rsp_s, 32'h0);
    checkOutput("t6_add_carry", bus.rsp_carry, 1);
    checkOutput("t6_add_of", bus.rsp_of, 0);
    checkOutput("t6_add_eq", bus.rsp_eq, 0);
    tick();
    applyStimulus(0, OP_SUB, 32'h80000000, 32'h00000001);
    tick();
    dropRequest(0);
    tick();
    checkOutput("t6_sub_s", bus.rsp_s, 32'h7FFFFFFF);
    checkOutput("t6_sub_carry", bus.rsp_carry, 1);
    checkOutput("t6_sub_of", bus.rsp_of, 1);
    tick();

    // Test 5: reset during EXEC drops the operation
    applyStimulus(1, OP_XOR, 32'hA5A5A5A5, 32'h0);
    tick();
    dropRequest(1);
    checkOutput("t5_exec_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_busy", bus.busy, 0);
    checkOutput("t5_rst_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("t5_rst_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("t5_rst_rsp_s", bus.rsp_s, 0);
    checkOutput("t5_rst_rsp_err", bus.rsp_err, 0);
    checkOutput("t5_rst_rsp_carry", bus.rsp_carry, 0);
    checkOutput("t5_rst_alu_a", bus.alu_a, 0);
    checkOutput("t5_rst_alu_op", bus.alu_op, 0);
    rst = 1'b0;
    tick();
    checkOutput("t5_post_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("t5_post_busy", bus.busy, 0);
    tick();
    checkOutput("t5_post2_rsp1_valid", bus.rsp1_valid, 0);
    applyStimulus(0, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    applyStimulus(1, OP_XOR, 32'h1, 32'h1);
    #1;
    checkOutput("t5_tie_req0_ready", bus.req0_ready, 1);
    checkOutput("t5_tie_req1_ready", bus.req1_ready, 0);
    tick();
    dropRequest(0);
    dropRequest(1);
    tick();
    checkOutput("t5_tie_rsp0_valid", bus.rsp0_valid, 1);
    checkOutput("t5_tie_rsp_s", bus.rsp_s, 32'hF000F000);
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
